// File: rtl/store_port_arbiter_pkg.sv
// store_port_arbiter_pkg: shared state encodings, requester indices and defaults
package store_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_C = 2;
  localparam int REQ_D = 3;
  localparam int DEF_TIMEOUT_CYC = 16;
endpackage

// File: rtl/store_port_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin pick starting the scan at ptr
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;
  assign dbl = {req, req};
  assign rot = dbl[ptr +: 4];
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign winner = ptr + off;
  assign any = |req;
endmodule

// File: rtl/store_port_arbiter.sv
// store_port_arbiter: round-robin owner of the store port with bursts and timeout abort
module store_port_arbiter
  import store_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       mem_valid,
  output logic [3:0] done,
  output logic       err,
  output logic       busy
);
  state_t state, state_n;
  logic [1:0] rr_ptr, ptr_n, sel_n, winner;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] done_n;
  logic err_n, any;
  rr_pick4 u_pick (.req(req), .ptr(rr_ptr), .winner(winner), .any(any));
  assign mem_valid = state == ST_GRANT;
  assign busy = state != ST_IDLE;
  // next-state: arbitration in IDLE, handshake > withdrawal > timeout in GRANT
  always_comb begin
    state_n = state;
    sel_n = sel;
    ptr_n = rr_ptr;
    cnt_n = cnt;
    done_n = '0;
    err_n = 1'b0;
    case (state)
      ST_IDLE: if (any) begin
        sel_n = winner;
        cnt_n = '0;
        state_n = ST_GRANT;
      end
      ST_GRANT: begin
        cnt_n = cnt + CNT_W'(1);
        if (mem_ready) begin
          done_n = 4'(1) << sel;
          cnt_n = '0;
          if (!(lock[sel] && req[sel])) begin
            state_n = ST_GAP;
            ptr_n = sel + 2'd1;
          end
        end else if (!req[sel] || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_n = ST_GAP;
          ptr_n = sel + 2'd1;
          err_n = req[sel];
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end
  // registered state and outputs; grant follows the owner only while in GRANT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel <= 2'b00;
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      rr_ptr <= 2'b00;
      cnt <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      gnt <= (state_n == ST_GRANT) ? 4'(1) << sel_n : 4'b0;
      done <= done_n;
      err <= err_n;
      rr_ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_store_port_arbiter.sv
// tb_store_port_arbiter: directed table and sequence checks of the store port arbiter
module tb_store_port_arbiter;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, mem_valid, err, busy;
  logic [3:0] req = '0, lock = '0, gnt, done;
  logic [1:0] sel;
  int checks = 0, passed = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic rdy;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[15];
  store_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .mem_ready(mem_ready),
    .sel(sel), .gnt(gnt), .mem_valid(mem_valid), .done(done), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] ex(logic [1:0] s, logic [3:0] g, logic v, logic [3:0] d, logic e, logic b);
    return {s, g, v, d, e, b};
  endfunction
  function automatic logic [12:0] obs();
    return {sel, gnt, mem_valid, done, err, busy};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] req_v);
    checks++;
    if (act === req_v) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req_v);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    lock = '0;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    int mv_n, err_n, done_n;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] s;
      logic [3:0] g;
      s = 2'(k);
      g = 4'(1) << s;
      tbl[3*k]   = '{4'b1111, 4'b0, 1'b1, ex(s, g, 1'b1, 4'b0, 1'b0, 1'b1)};
      tbl[3*k+1] = '{4'b1111, 4'b0, 1'b1, ex(s, 4'b0, 1'b0, g, 1'b0, 1'b1)};
      tbl[3*k+2] = '{4'b1111, 4'b0, 1'b1, ex(s, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0)};
    end
    do_reset();
    chk("reset_state", 32'(obs()), 32'(ex(2'b00, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0)));
    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req;
      lock = tbl[i].lock;
      mem_ready = tbl[i].rdy;
      step();
      chk($sformatf("rr_vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    do_reset();
    req = 4'b0100;
    mem_ready = 1'b1;
    step();
    chk("single_grant", 32'(obs()), 32'(ex(2'b10, 4'b0100, 1'b1, 4'b0, 1'b0, 1'b1)));
    req = 4'b0000;
    step();
    chk("single_done", 32'(obs()), 32'(ex(2'b10, 4'b0, 1'b0, 4'b0100, 1'b0, 1'b1)));
    req = 4'b1111;
    step();
    chk("single_idle", 32'(obs()), 32'(ex(2'b10, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0)));
    step();
    chk("single_next_d", 32'(obs()), 32'(ex(2'b11, 4'b1000, 1'b1, 4'b0, 1'b0, 1'b1)));
    do_reset();
    req = 4'b0011;
    lock = 4'b0001;
    mem_ready = 1'b1;
    step();
    chk("burst_entry", 32'(obs()), 32'(ex(2'b00, 4'b0001, 1'b1, 4'b0, 1'b0, 1'b1)));
    for (int b = 0; b < 3; b++) begin
      step();
      chk($sformatf("burst_beat%0d", b), 32'(obs()), 32'(ex(2'b00, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1)));
    end
    lock = 4'b0000;
    step();
    chk("burst_last", 32'(obs()), 32'(ex(2'b00, 4'b0, 1'b0, 4'b0001, 1'b0, 1'b1)));
    step();
    step();
    chk("burst_then_b", 32'(obs()), 32'(ex(2'b01, 4'b0010, 1'b1, 4'b0, 1'b0, 1'b1)));
    do_reset();
    req = 4'b1000;
    step();
    mv_n = 0;
    err_n = 0;
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      mv_n += int'(mem_valid);
      err_n += int'(err);
      done_n += int'(|done);
      if (!mem_valid) req = 4'b0000;
      step();
    end
    chk("timeout_valid_cycles", 32'(mv_n), 32'd16);
    chk("timeout_err_pulses", 32'(err_n), 32'd1);
    chk("timeout_no_done", 32'(done_n), 32'd0);
    req = 4'b0001;
    step();
    chk("timeout_next_a", 32'(obs()), 32'(ex(2'b00, 4'b0001, 1'b1, 4'b0, 1'b0, 1'b1)));
    do_reset();
    req = 4'b0010;
    step();
    step();
    step();
    chk("wd_third_cycle", 32'(obs()), 32'(ex(2'b01, 4'b0010, 1'b1, 4'b0, 1'b0, 1'b1)));
    req = 4'b0000;
    step();
    chk("wd_gap", 32'(obs()), 32'(ex(2'b01, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1)));
    req = 4'b0111;
    step();
    step();
    chk("wd_next_c", 32'(obs()), 32'(ex(2'b10, 4'b0100, 1'b1, 4'b0, 1'b0, 1'b1)));
    do_reset();
    req = 4'b1000;
    step();
    chk("mid_grant_d", 32'(obs()), 32'(ex(2'b11, 4'b1000, 1'b1, 4'b0, 1'b0, 1'b1)));
    rst = 1'b1;
    step();
    chk("mid_reset", 32'(obs()), 32'(ex(2'b00, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    req = 4'b1001;
    step();
    chk("mid_after_a", 32'(obs()), 32'(ex(2'b00, 4'b0001, 1'b1, 4'b0, 1'b0, 1'b1)));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
